// File: rtl/dffram_port_responder.sv
// Behavioural stand-in for the single-port DFFRAM macro: banked 16-word arrays,
// byte-masked writes, read-first registered read port, and a zero-fill sweep after reset.
module dffram_port_responder #(
  parameter  int WSIZE  = 4,
  parameter  int BANKS  = 8,
  localparam int AWIDTH = $clog2(BANKS) + 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 EN0,
  input  logic [WSIZE-1:0]     WE0,
  input  logic [AWIDTH-1:0]    A0,
  input  logic [8*WSIZE-1:0]   Di0,
  output logic [8*WSIZE-1:0]   Do0,
  output logic                 READY
);

  localparam int DW    = 8 * WSIZE;
  localparam int DEPTH = 16 * BANKS;
  localparam int BW    = AWIDTH - 4;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  state_e              state_r;
  state_e              state_nxt_s;
  logic [AWIDTH-1:0]   clr_cnt_r;
  logic [DW-1:0]       do0_r;
  logic                ready_r;

  logic                wr_en_s;
  logic [WSIZE-1:0]    wr_be_s;
  logic [AWIDTH-1:0]   wr_addr_s;
  logic [DW-1:0]       wr_data_s;
  logic                rd_en_s;
  logic [DW-1:0]       bank_rd_s [BANKS];

  // Next-state and write-port selection: the sweep owns the array until it finishes.
  always_comb begin
    state_nxt_s = state_r;
    wr_en_s     = 1'b0;
    wr_be_s     = '0;
    wr_addr_s   = clr_cnt_r;
    wr_data_s   = '0;
    rd_en_s     = 1'b0;
    case (state_r)
      ST_CLEAR: begin
        wr_en_s = 1'b1;
        wr_be_s = '1;
        if (clr_cnt_r == AWIDTH'(DEPTH - 1)) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_CLEAR;
        end
      end
      ST_IDLE: begin
        if (EN0) begin
          rd_en_s   = 1'b1;
          wr_en_s   = |WE0;
          wr_be_s   = WE0;
          wr_addr_s = A0;
          wr_data_s = Di0;
        end else begin
          rd_en_s   = 1'b0;
        end
      end
      default: begin
        state_nxt_s = ST_CLEAR;
      end
    endcase
  end

  // Control registers: FSM, sweep counter, read data and ready flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= ST_CLEAR;
      clr_cnt_r <= '0;
      do0_r     <= '0;
      ready_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ready_r <= (state_nxt_s == ST_IDLE);
      if (state_r == ST_CLEAR) begin
        clr_cnt_r <= clr_cnt_r + AWIDTH'(1);
      end
      if (rd_en_s) begin
        do0_r <= bank_rd_s[A0[AWIDTH-1:4]];
      end
    end
  end

  // Each bank decodes its own write strobe from the upper address bits.
  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic [DW-1:0] bank_mem_r [16];
    logic          bank_we_s;

    assign bank_we_s    = wr_en_s && !RST && (wr_addr_s[AWIDTH-1:4] == BW'(b));
    assign bank_rd_s[b] = bank_mem_r[A0[3:0]];

    // Byte-masked write into this bank's storage.
    always_ff @(posedge CLK) begin
      for (int i = 0; i < WSIZE; i++) begin
        if (bank_we_s && wr_be_s[i]) begin
          bank_mem_r[wr_addr_s[3:0]][8*i +: 8] <= wr_data_s[8*i +: 8];
        end
      end
    end
  end

  assign Do0   = do0_r;
  assign READY = ready_r;

endmodule
